uart_rx_oversampled: RTL

// - UART/RS232 receiver for the DE1 i_uart_rxd pin; sits directly downstream of the board top-level.
// - Synchronises the line, recovers frames by 16x oversampling with majority vote, and buffers one byte.
// - Presents the byte on a valid/ready stream with frame, parity and overrun error pulses.
// - Consumers are the command/console logic instantiated inside the top-level.

---
 rtl/sverdlovsk_uart_pkg.sv | 21 ++
 rtl/uart_rx_oversampled_baud_tick.sv | 30 +++
 rtl/uart_rx_oversampled.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sverdlovsk_uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider
// calculation, used by the receiver and the future transmitter.
package sverdlovsk_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_baud_tick.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks, phase
// realigned by i_restart.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap && !i_restart;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver with majority vote, one-entry output buffer
// on a valid/ready stream, and frame/parity/overrun error pulses.
module uart_rx_oversampled
  import sverdlovsk_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_err_frame,
  output logic                 o_err_parity,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic L_ODD = (PARITY_ODD != 0);

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  logic [1:0]           r_sync;
  logic                 r_rxd_d;
  logic                 w_rxd_s;
  logic                 w_fall;
  logic                 w_restart;
  logic                 w_tick;
  logic [TCW-1:0]       r_tick_cnt;
  logic [2:0]           r_samp;
  logic                 r_vote_en;
  logic                 w_vote;
  uart_rx_state_t       r_state;
  uart_rx_state_t       w_next;
  logic                 w_shift_en;
  logic                 w_par_chk;
  logic                 w_deliver;
  logic                 w_ferr;
  logic                 w_perr;
  logic [BCW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_err_frame;
  logic                 r_err_parity;
  logic                 r_overrun;

  assign w_rxd_s   = r_sync[1];
  assign w_fall    = r_rxd_d & ~w_rxd_s;
  assign w_restart = (r_state == IDLE) && w_fall;
  assign w_vote    = maj3(r_samp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_rxd_d <= w_rxd_s;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // The vote strobe fires the cycle after the last mid-bit sample lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
      r_samp     <= 3'b111;
      r_vote_en  <= 1'b0;
    end else begin
      r_vote_en <= w_tick && (r_tick_cnt == TCW'(OVERSAMPLE / 2 + 1));
      if (w_restart) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_samp     <= {r_samp[1:0], w_rxd_s};
        r_tick_cnt <= (r_tick_cnt == TCW'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + TCW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_par_chk  = 1'b0;
    w_deliver  = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
    case (r_state)
      IDLE: if (w_fall) w_next = START;
      START: if (r_vote_en) w_next = w_vote ? IDLE : DATA;
      DATA: begin
        if (r_vote_en) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BCW'(DATA_BITS - 1)) begin
            w_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (r_vote_en) begin
          w_par_chk = 1'b1;
          w_next    = STOP;
        end
      end
      STOP: begin
        if (r_vote_en) begin
          if (!w_vote) begin
            w_ferr = 1'b1;
            w_next = BREAK;
          end else if (r_par_err) begin
            w_perr = 1'b1;
            w_next = IDLE;
          end else begin
            w_deliver = 1'b1;
            w_next    = IDLE;
          end
        end
      end
      BREAK: if (w_rxd_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (w_restart) begin
        r_bit_cnt <= '0;
        r_par_err <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
      if (w_par_chk) begin
        r_par_err <= w_vote ^ (^r_shift) ^ L_ODD;
      end
    end
  end

  // A full buffer keeps its byte unless it is being accepted this same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_err_frame  <= 1'b0;
      r_err_parity <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_err_frame  <= w_ferr;
      r_err_parity <= w_perr;
      r_overrun    <= w_deliver && r_valid && !i_ready;
      if (w_deliver && (!r_valid || i_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_err_frame  = r_err_frame;
  assign o_err_parity = r_err_parity;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != IDLE);

endmodule
